matmul_arbiter: RTL and testbench

MATMUL_ARBITER -- requirements
Module: matmul_arbiter

---
 rtl/attention_pkg.sv | 12 +
 rtl/matmul_arbiter_rr_pick.sv | 35 +++
 rtl/matmul_arbiter.sv | 136 +++++++++++++
 tb/tb_matmul_arbiter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/attention_pkg.sv
// Shared types for the attention datapath control blocks.
// Holds the state encoding of the matmul engine arbiter.
package attention_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    WAIT    = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

endpackage

// File: rtl/matmul_arbiter_rr_pick.sv
// Round-robin winner selection for the matmul arbiter.
// Purely combinational: the search begins just after last_owner, wraps
// modulo NUM_REQ, and the first asserted request bit wins.
module rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last_owner,
  output logic                       valid,
  output logic [NUM_REQ-1:0]         onehot,
  output logic [$clog2(NUM_REQ)-1:0] index
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] pos;

  // Scan from the farthest offset back to the nearest so the nearest set bit after last_owner overrides
  always_comb begin
    valid  = 1'b0;
    onehot = '0;
    index  = '0;
    pos    = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      pos = IDX_W'((int'(last_owner) + off) % NUM_REQ);
      if (req[pos]) begin
        valid       = 1'b1;
        onehot      = '0;
        onehot[pos] = 1'b1;
        index       = pos;
      end
    end
  end

endmodule

// File: rtl/matmul_arbiter.sv
// Round-robin arbiter sharing one matmul_array engine among NUM_REQ requesters.
// Sequence per transaction: IDLE -> GRANT (mm_start pulse) -> WAIT (for mm_done)
// -> RELEASE (req_done pulse to the owner) -> IDLE.
// Optional feature: define ARB_TIMEOUT_EN to add a WAIT-state watchdog that
// forces RELEASE with a timeout pulse after TIMEOUT_CYCLES cycles without mm_done.
module matmul_arbiter
  import attention_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  output logic [NUM_REQ-1:0]         grant,
  output logic [NUM_REQ-1:0]         req_done,
  output logic                       mm_start,
  input  logic                       mm_done,
  output logic [$clog2(NUM_REQ)-1:0] mm_sel,
  output logic                       busy,
  output logic                       timeout
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_t         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   sel_q, sel_d;
  logic [IDX_W-1:0]   last_owner_q, last_owner_d;

  logic               pick_valid;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0]   pick_index;
  logic               wd_fire;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req        (req),
    .last_owner (last_owner_q),
    .valid      (pick_valid),
    .onehot     (pick_onehot),
    .index      (pick_index)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wdog_q;
  logic            timeout_q;

  // Watchdog counts WAIT cycles, restarting on every entry into WAIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q <= '0;
    end else if (state_q == GRANT) begin
      wdog_q <= '0;
    end else if (state_q == WAIT) begin
      wdog_q <= wdog_q + 1'b1;
    end
  end

  // Fire on the WAIT cycle that brings the count to TIMEOUT_CYCLES; a same-cycle mm_done takes priority
  assign wd_fire = (state_q == WAIT) && !mm_done && (wdog_q == WD_W'(TIMEOUT_CYCLES - 1));

  // Timeout pulse is registered so it lines up with the RELEASE cycle and req_done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= wd_fire;
    end
  end

  assign timeout = timeout_q;
`else
  assign wd_fire = 1'b0;
  assign timeout = 1'b0;
`endif

  // State, owner and round-robin pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      sel_q        <= '0;
      last_owner_q <= IDX_W'(NUM_REQ - 1);
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      sel_q        <= sel_d;
      last_owner_q <= last_owner_d;
    end
  end

  // Next-state logic: latch the winner in IDLE, hold ownership until RELEASE hands it back
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    sel_d        = sel_q;
    last_owner_d = last_owner_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d = pick_onehot;
          sel_d   = pick_index;
          state_d = GRANT;
        end
      end
      GRANT: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (mm_done || wd_fire) begin
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        last_owner_d = sel_q;
        grant_d      = '0;
        state_d      = IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign grant    = grant_q;
  assign mm_sel   = sel_q;
  assign mm_start = (state_q == GRANT);
  assign req_done = (state_q == RELEASE) ? grant_q : '0;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_matmul_arbiter.sv
// Self-checking bench for matmul_arbiter: directed scenarios followed by
// randomized requests and engine completions, all compared every cycle
// against a transaction-level reference model.
module tb_matmul_arbiter;

  localparam int NUM_REQ        = 4;
  localparam int TIMEOUT_CYCLES = 8;
`ifdef ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic                 clk;
  logic                 rst_n;
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ-1:0]   grant;
  logic [NUM_REQ-1:0]   req_done;
  logic                 mm_start;
  logic                 mm_done;
  logic [1:0]           mm_sel;
  logic                 busy;
  logic                 timeout;

  int n_compared   = 0;
  int n_mismatched = 0;

  // Reference model: who owns the engine, how long they have had it, and whether
  // the current cycle is the hand-back cycle.
  int m_owner;
  int m_last;
  int m_sel;
  int m_age;
  bit m_rel;
  bit m_tmo;

  matmul_arbiter #(
    .NUM_REQ        (NUM_REQ),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .grant    (grant),
    .req_done (req_done),
    .mm_start (mm_start),
    .mm_done  (mm_done),
    .mm_sel   (mm_sel),
    .busy     (busy),
    .timeout  (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_owner = -1;
    m_last  = NUM_REQ - 1;
    m_sel   = 0;
    m_age   = 0;
    m_rel   = 1'b0;
    m_tmo   = 1'b0;
  endtask

  // One clock of the reference: arbitration, the one-cycle start, waiting, hand-back
  task automatic modelStep(input logic [NUM_REQ-1:0] r, input logic d);
    int  p;
    bit  found;
    if (m_owner < 0) begin
      found = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
        p = (m_last + k) % NUM_REQ;
        if (!found && r[p]) begin
          found   = 1'b1;
          m_owner = p;
        end
      end
      if (found) begin
        m_sel = m_owner;
        m_age = 0;
        m_rel = 1'b0;
        m_tmo = 1'b0;
      end
    end else if (m_rel) begin
      m_last  = m_owner;
      m_owner = -1;
      m_rel   = 1'b0;
      m_tmo   = 1'b0;
    end else if (m_age == 0) begin
      m_age = 1;
    end else if (d) begin
      m_rel = 1'b1;
    end else if (TMO_EN && m_age == TIMEOUT_CYCLES) begin
      m_rel = 1'b1;
      m_tmo = 1'b1;
    end else begin
      m_age++;
    end
  endtask

  function automatic logic [NUM_REQ-1:0] expGrant();
    return (m_owner >= 0) ? NUM_REQ'(1 << m_owner) : '0;
  endfunction

  task automatic checkAll(input string phase);
    checkOutput({phase, ".grant"},    32'(grant),    32'(expGrant()));
    checkOutput({phase, ".req_done"}, 32'(req_done), m_rel ? 32'(expGrant()) : 32'd0);
    checkOutput({phase, ".mm_start"}, 32'(mm_start), 32'(m_owner >= 0 && m_age == 0));
    checkOutput({phase, ".busy"},     32'(busy),     32'(m_owner >= 0));
    checkOutput({phase, ".timeout"},  32'(timeout),  32'(m_rel && m_tmo));
    checkOutput({phase, ".mm_sel"},   32'(mm_sel),   32'(m_sel));
  endtask

  task automatic checkResetOutputs(input string phase);
    checkOutput({phase, ".grant"},    32'(grant),    32'd0);
    checkOutput({phase, ".req_done"}, 32'(req_done), 32'd0);
    checkOutput({phase, ".mm_start"}, 32'(mm_start), 32'd0);
    checkOutput({phase, ".mm_sel"},   32'(mm_sel),   32'd0);
    checkOutput({phase, ".busy"},     32'(busy),     32'd0);
    checkOutput({phase, ".timeout"},  32'(timeout),  32'd0);
  endtask

  // Drive inputs on the falling edge, advance one rising edge, check on the next falling edge
  task automatic applyStimulus(input string phase, input logic [NUM_REQ-1:0] r, input logic d);
    req     = r;
    mm_done = d;
    @(posedge clk);
    modelStep(r, d);
    @(negedge clk);
    checkAll(phase);
  endtask

  initial begin
    logic [NUM_REQ-1:0] rq;
    rst_n   = 1'b0;
    req     = '0;
    mm_done = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkResetOutputs("reset");
    rst_n = 1'b1;

    // Single request from requester 2, engine finishes after five waiting cycles
    applyStimulus("single", 4'b0100, 1'b0);
    checkOutput("single.grant_const", 32'(grant), 32'h4);
    checkOutput("single.sel_const",   32'(mm_sel), 32'd2);
    repeat (5) applyStimulus("single", 4'b0100, 1'b0);
    applyStimulus("single", 4'b0100, 1'b1);
    checkOutput("single.done_const", 32'(req_done), 32'h4);
    applyStimulus("single", 4'b0000, 1'b0);

    // Wrap and skip: last owner is 2, so 0 then 1
    for (int i = 0; i < 10; i++) applyStimulus("wrap", 4'b0011, (i % 4) == 2);

    // All four requesting: strict rotation
    for (int i = 0; i < 24; i++) applyStimulus("rotate", 4'b1111, (i % 5) == 3);
    applyStimulus("rotate", 4'b0000, 1'b0);
    applyStimulus("rotate", 4'b0000, 1'b0);

    // Spurious mm_done in IDLE and in GRANT
    applyStimulus("spurious", 4'b0000, 1'b1);
    applyStimulus("spurious", 4'b0000, 1'b1);
    applyStimulus("spurious", 4'b1000, 1'b0);
    applyStimulus("spurious", 4'b1000, 1'b1);
    applyStimulus("spurious", 4'b1000, 1'b0);

    // Engine never answers: watchdog fires or WAIT persists depending on build
    for (int i = 0; i < TIMEOUT_CYCLES + 6; i++) applyStimulus("watchdog", 4'b1000, 1'b0);
    applyStimulus("watchdog", 4'b0000, 1'b1);
    applyStimulus("watchdog", 4'b0000, 1'b0);
    applyStimulus("watchdog", 4'b0000, 1'b0);

    // Reset while waiting abandons the transaction
    applyStimulus("rstwait", 4'b0010, 1'b0);
    applyStimulus("rstwait", 4'b0010, 1'b0);
    applyStimulus("rstwait", 4'b0010, 1'b0);
    rst_n = 1'b0;
    #1;
    checkResetOutputs("rstwait.async");
    modelReset();
    @(posedge clk);
    @(negedge clk);
    checkResetOutputs("rstwait.held");
    rst_n = 1'b1;
    applyStimulus("rstwait", 4'b0001, 1'b0);
    checkOutput("rstwait.grant_const", 32'(grant), 32'h1);
    applyStimulus("rstwait", 4'b0001, 1'b0);
    applyStimulus("rstwait", 4'b0001, 1'b1);
    applyStimulus("rstwait", 4'b0000, 1'b0);
    applyStimulus("rstwait", 4'b0000, 1'b0);

    // Randomized traffic: requests stay high until served, owners occasionally drop early
    rq = '0;
    for (int c = 0; c < 3000; c++) begin
      if (m_rel) rq = rq & ~expGrant();
      if ($urandom_range(0, 2) == 0) rq = rq | NUM_REQ'($urandom_range(0, 15));
      if (m_owner >= 0 && $urandom_range(0, 40) == 0) rq[m_owner] = 1'b0;
      applyStimulus("random", rq, $urandom_range(0, 3) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
